// File: rtl/spi_pkg.sv
// Shared types for the multi-slave SPI master: FSM state encoding and the
// latched SPI mode (clock polarity / phase).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK divider: counts CLK_DIV system clocks per tick and, while toggling is
// enabled, flips the SCLK phase on every tick with leading/trailing strobes.
module spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic toggle_en,
  input  logic cpol,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  // phase 0 is the idle level, so SCLK follows the latched polarity outside XFER
  assign tick  = enable && (div_q == DIV_LAST);
  assign lead  = tick && toggle_en && !phase_q;
  assign trail = tick && toggle_en && phase_q;
  assign sclk  = cpol ^ phase_q;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!enable) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick && toggle_en) begin
        phase_d = ~phase_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with NUM_SLAVES active-low chip selects, run-time selectable
// mode (cpol/cpha) and a CLK_DIV-divided serial clock.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int CLK_DIV    = 2,
  localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slaveSelect,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int HALF_W = $clog2(2 * DATA_WIDTH);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  spi_mode_t             mode_q, mode_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;

  logic tick, lead, trail;
  logic accept, last_half, sample, shift;

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .enable   (state_q != IDLE),
    .toggle_en(state_q == XFER),
    .cpol     (mode_q.cpol),
    .tick     (tick),
    .lead     (lead),
    .trail    (trail),
    .sclk     (SCLK)
  );

  // the done cycle is already IDLE, so it is excluded explicitly
  assign accept = (state_q == IDLE) && !done_q && start &&
                  ({1'b0, slaveSelect} < (SEL_W + 1)'(NUM_SLAVES));
  assign last_half = (half_q == LAST_HALF);
  assign sample    = mode_q.cpha ? trail : lead;
  assign shift     = mode_q.cpha ? lead : (trail && !last_half);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)             state_d = LEAD;
      LEAD:  if (tick)               state_d = XFER;
      XFER:  if (tick && last_half)  state_d = TRAIL;
      TRAIL: if (tick)               state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    sel_d   = sel_q;
    half_d  = half_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    mosi_d  = mosi_q;
    done_d  = (state_q == TRAIL) && tick;

    if (accept) begin
      mode_d = '{cpol: cpol, cpha: cpha};
      sel_d  = slaveSelect;
      half_d = '0;
      if (cpha) begin
        tx_d = masterDataToSend;
      end else begin
        mosi_d = masterDataToSend[DATA_WIDTH-1];
        tx_d   = {masterDataToSend[DATA_WIDTH-2:0], 1'b0};
      end
    end

    if ((state_q == XFER) && tick) begin
      half_d = last_half ? '0 : half_q + HALF_W'(1);
    end
    if (shift) begin
      mosi_d = tx_q[DATA_WIDTH-1];
      tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
    end
    if (sample) begin
      rx_d = {rx_q[DATA_WIDTH-2:0], MISO};
    end
    if (done_d) begin
      rdata_d = rx_q;
    end
  end

  always_comb begin
    busy               = (state_q != IDLE);
    done               = done_q;
    MOSI               = mosi_q;
    masterDataReceived = rdata_q;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      CS[i] = !((state_q != IDLE) && (sel_q == SEL_W'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= '0;
      sel_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench: instance A (8-bit, div 2) talks to a behavioural slave,
// instance B (16-bit, div 1, three selects) runs with MISO looped back to MOSI.
module tb_spi_master_multi;

  typedef struct {
    logic [15:0] mrx;
    logic [15:0] srx;
    logic        chk_srx;
    int          lat;
    logic [3:0]  cs;
    int          edges;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   t_start = 0;
  int   n_err = 0;
  int   n_chk = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0, miso_a = 1'b0;
  logic [1:0] sel_a = '0;
  logic [7:0] tx_a = '0;
  logic [7:0] rx_a;
  logic       busy_a, done_a, sclk_a, mosi_a;
  logic [3:0] cs_a;

  spi_master_multi #(.DATA_WIDTH(8), .NUM_SLAVES(4), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .slaveSelect(sel_a),
    .cpol(cpol_a), .cpha(cpha_a), .masterDataToSend(tx_a),
    .masterDataReceived(rx_a), .busy(busy_a), .done(done_a),
    .SCLK(sclk_a), .CS(cs_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  logic        start_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0;
  logic [1:0]  sel_b = '0;
  logic [15:0] tx_b = '0;
  logic [15:0] rx_b;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic [2:0]  cs_b;

  spi_master_multi #(.DATA_WIDTH(16), .NUM_SLAVES(3), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .slaveSelect(sel_b),
    .cpol(cpol_b), .cpha(cpha_b), .masterDataToSend(tx_b),
    .masterDataReceived(rx_b), .busy(busy_b), .done(done_b),
    .SCLK(sclk_b), .CS(cs_b), .MOSI(mosi_b), .MISO(mosi_b)
  );

  // slave for instance A, reacting to SCLK edges seen on the falling clk edge
  logic [7:0] slave_word = '0, s_tx = '0, s_rx = '0;
  logic       s_loaded = 1'b0, s_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_a == 4'hF) begin
      s_loaded <= 1'b0;
    end else if (!s_loaded) begin
      s_loaded <= 1'b1;
      s_prev   <= sclk_a;
      s_tx     <= slave_word;
      s_rx     <= '0;
      if (!cpha_a) miso_a <= slave_word[7];
    end else if (sclk_a != s_prev) begin
      s_prev <= sclk_a;
      if ((s_prev == cpol_a) != cpha_a) begin
        s_rx <= {s_rx[6:0], mosi_a};
      end else begin
        miso_a <= cpha_a ? s_tx[7] : s_tx[6];
        s_tx   <= {s_tx[6:0], 1'b0};
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input bit use_b, input logic [1:0] sel, input bit pol,
                               input bit pha, input logic [15:0] data,
                               input logic [15:0] sdata, input bit hold);
    exp_t e;
    @(negedge clk);
    if (use_b) begin
      sel_b = sel; cpol_b = pol; cpha_b = pha; tx_b = data; start_b = 1'b1;
      e.mrx = data; e.srx = '0; e.chk_srx = 1'b0;
      e.lat = 34; e.edges = 32; e.cs = {1'b0, ~(3'b001 << sel)};
    end else begin
      sel_a = sel; cpol_a = pol; cpha_a = pha; tx_a = data[7:0]; start_a = 1'b1;
      slave_word = sdata[7:0];
      e.mrx = {8'h00, sdata[7:0]}; e.srx = {8'h00, data[7:0]}; e.chk_srx = 1'b1;
      e.lat = 36; e.edges = 16; e.cs = ~(4'b0001 << sel);
    end
    sb.push_back(e);
    @(negedge clk);
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    t_start = cyc;
  endtask

  task automatic runXfer(input bit use_b, input string tag);
    exp_t       e;
    int         lat, edges;
    bit         cs_ok;
    logic       prev, cur;
    logic [3:0] cs_now;
    lat = -1; edges = 0; cs_ok = 1'b1;
    e = sb.pop_front();
    prev = use_b ? sclk_b : sclk_a;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        lat = cyc - t_start;
        break;
      end
      cur = use_b ? sclk_b : sclk_a;
      if (cur != prev) edges++;
      prev = cur;
      cs_now = use_b ? {1'b0, cs_b} : cs_a;
      if (cs_now != e.cs) cs_ok = 1'b0;
    end
    checkOutput({tag, "_rx"}, use_b ? rx_b : {8'h00, rx_a}, e.mrx);
    checkOutput({tag, "_latency"}, lat, e.lat);
    checkOutput({tag, "_sclk_edges"}, edges, e.edges);
    checkOutput({tag, "_cs_during"}, cs_ok, 1);
    if (e.chk_srx) checkOutput({tag, "_slave_rx"}, s_rx, e.srx[7:0]);
  endtask

  initial begin
    int   edges;
    logic prev;
    bit   saw_done;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_cs", cs_a, 4'hF);
    checkOutput("rst_sclk", sclk_a, 0);
    checkOutput("rst_mosi", mosi_a, 0);
    checkOutput("rst_rx", rx_a, 0);
    checkOutput("rst_cs_b", cs_b, 3'h7);
    reset = 1'b0;

    $display("[TB] mode 0 exchange on select 1");
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b0, 16'h0053, 16'h0009, 1'b0);
    runXfer(1'b0, "m0");
    repeat (3) @(negedge clk);
    checkOutput("m0_rx_hold", rx_a, 8'h09);

    $display("[TB] mode 3 exchange on select 2");
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b1, 16'h003C, 16'h0098, 1'b0);
    checkOutput("m3_sclk_idle_before", sclk_a, 1);
    runXfer(1'b0, "m3");
    @(negedge clk);
    checkOutput("m3_sclk_idle_after", sclk_a, 1);

    $display("[TB] 16-bit loopback in all modes");
    for (int m = 0; m < 4; m++) begin
      applyStimulus(1'b1, 2'(m % 3), m[1], m[0], 16'hA5C3, 16'h0000, 1'b0);
      runXfer(1'b1, $sformatf("lb%0d", m));
    end

    $display("[TB] out-of-range select");
    @(negedge clk);
    sel_b = 2'd3; start_b = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("oor_busy", busy_b, 0);
    checkOutput("oor_cs", cs_b, 3'h7);
    start_b = 1'b0;

    $display("[TB] start held through a transfer");
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 16'h0011, 16'h0022, 1'b1);
    tx_a = 8'hEE; sel_a = 2'd3; cpha_a = 1'b1;
    runXfer(1'b0, "hold");
    @(negedge clk);
    checkOutput("hold_done_cycle_ignored", busy_a, 0);
    start_a = 1'b0;

    $display("[TB] reset during XFER");
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0, 16'h0077, 16'h0055, 1'b0);
    edges = 0;
    prev = sclk_a;
    for (int k = 0; k < 200 && edges < 6; k++) begin
      @(negedge clk);
      if (sclk_a != prev) edges++;
      prev = sclk_a;
    end
    checkOutput("abort_reached_bit3", edges, 6);
    reset = 1'b1;
    #1;
    checkOutput("abort_cs", cs_a, 4'hF);
    checkOutput("abort_sclk", sclk_a, 0);
    checkOutput("abort_busy", busy_a, 0);
    saw_done = done_a;
    repeat (4) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
    end
    reset = 1'b0;
    checkOutput("abort_no_done", saw_done, 0);
    void'(sb.pop_front());
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b0, 16'h0053, 16'h0009, 1'b0);
    runXfer(1'b0, "post_rst");

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
